// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared state encoding, source IDs and trap vector constants
package interrupt_controller_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_e;
  typedef enum logic [2:0] {SRC_NMI, SRC_IRQ0, SRC_IRQ1, SRC_IRQ2, SRC_IRQ3} src_e;
  localparam logic [8:0] VEC_NMI = 9'd480;
  localparam logic [8:0] VEC_BASE = 9'd448;
  localparam logic [8:0] VEC_STRIDE = 9'd8;
  function automatic logic [8:0] src_vector(input src_e s);
    return s == SRC_NMI ? VEC_NMI : VEC_BASE + VEC_STRIDE * (9'(s) - 9'd1);
  endfunction
endpackage

// File: rtl/interrupt_controller_int_priority_encoder.sv
// int_priority_encoder: fixed-priority pick of NMI over irq[0..3], lowest index first
module int_priority_encoder
  import interrupt_controller_pkg::*;
(
  input  logic       nmi_pend,
  input  logic [3:0] req,
  output logic       valid,
  output logic [2:0] src
);
  always_comb begin
    valid = nmi_pend | (|req);
    src = nmi_pend ? SRC_NMI : req[0] ? SRC_IRQ0 : req[1] ? SRC_IRQ1 :
          req[2] ? SRC_IRQ2 : req[3] ? SRC_IRQ3 : SRC_NMI;
  end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched NMI/irq requests arbitrated into an IDLE/REQ/SERVICE handshake with the CU
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] irq,
  input  logic       nmi,
  input  logic       maskWe,
  input  logic [3:0] maskIn,
  input  logic       intEnable,
  input  logic       intAck,
  input  logic       intDone,
  output logic       hardwareInterrupt,
  output logic       maskableInterrupt,
  output logic [8:0] intVector,
  output logic [3:0] pending,
  output logic       inService
);
  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] pend_q, pend_d, mask_q, mask_d, irq_prev_q;
  logic       nmi_pend_q, nmi_pend_d, nmi_prev_q;
  logic       hw_q, hw_d, mi_q, mi_d, svc_q, svc_d;
  logic [8:0] vec_q, vec_d;
  logic [3:0] arb_req, irq_evt, irq_clr;
  logic [2:0] arb_src;
  logic       arb_valid, nmi_evt, nmi_clr, ack, grant;
  assign arb_req = pend_q & ~mask_q & {4{intEnable}};
  int_priority_encoder u_enc (
    .nmi_pend(nmi_pend_q),
    .req     (arb_req),
    .valid   (arb_valid),
    .src     (arb_src)
  );
  always_comb begin
    irq_evt = irq & ~irq_prev_q;
    nmi_evt = nmi & ~nmi_prev_q;
    ack = state_q == ST_REQ && intAck;
    grant = state_q == ST_IDLE && arb_valid;
    nmi_clr = ack && sel_q == SRC_NMI;
    irq_clr = ack && sel_q != SRC_NMI ? 4'b1 << (sel_q - 3'd1) : 4'b0;
    pend_d = (pend_q & ~irq_clr) | irq_evt;
    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_evt;
    mask_d = maskWe ? maskIn : mask_q;
    state_d = grant ? ST_REQ : ack ? ST_SERVICE :
              state_q == ST_SERVICE && intDone ? ST_IDLE : state_q;
    sel_d = grant ? arb_src : sel_q;
    hw_d = state_d == ST_REQ && sel_d == SRC_NMI;
    mi_d = state_d == ST_REQ && sel_d != SRC_NMI;
    svc_d = state_d == ST_SERVICE;
    vec_d = state_d == ST_IDLE ? 9'd0 : src_vector(src_e'(sel_d));
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q <= SRC_NMI;
      pend_q <= '0;
      nmi_pend_q <= 1'b0;
      mask_q <= 4'hF;
      irq_prev_q <= irq;
      nmi_prev_q <= nmi;
      hw_q <= 1'b0;
      mi_q <= 1'b0;
      svc_q <= 1'b0;
      vec_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      pend_q <= pend_d;
      nmi_pend_q <= nmi_pend_d;
      mask_q <= mask_d;
      irq_prev_q <= irq;
      nmi_prev_q <= nmi;
      hw_q <= hw_d;
      mi_q <= mi_d;
      svc_q <= svc_d;
      vec_q <= vec_d;
    end
  end
  assign hardwareInterrupt = hw_q;
  assign maskableInterrupt = mi_q;
  assign intVector = vec_q;
  assign pending = pend_q;
  assign inService = svc_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vector table plus randomized run against a behavioural model
module tb_interrupt_controller;
  logic Clk = 1'b0;
  logic reset, nmi, maskWe, intEnable, intAck, intDone;
  logic [3:0] irq, maskIn, pending;
  logic hardwareInterrupt, maskableInterrupt, inService;
  logic [8:0] intVector;
  int vectors = 0, miscompares = 0;
  always #5 Clk = ~Clk;
  interrupt_controller dut (
    .Clk(Clk), .reset(reset), .irq(irq), .nmi(nmi), .maskWe(maskWe), .maskIn(maskIn),
    .intEnable(intEnable), .intAck(intAck), .intDone(intDone),
    .hardwareInterrupt(hardwareInterrupt), .maskableInterrupt(maskableInterrupt),
    .intVector(intVector), .pending(pending), .inService(inService)
  );
  typedef struct {
    logic rst; logic [3:0] irq; logic nmi, we; logic [3:0] min; logic en, ack, done;
    logic hw, mi; logic [8:0] vec; logic [3:0] pend; logic svc;
  } vec_t;
  vec_t tbl[$];
  int mode, sel;
  bit [3:0] m_pend, m_mask, m_prev;
  bit m_nmi, m_nprev;
  function automatic void add(input logic rst, input logic [3:0] i, input logic n, input logic we,
                              input logic [3:0] min, input logic en, input logic ack, input logic done,
                              input logic hw, input logic mi, input logic [8:0] vec,
                              input logic [3:0] pend, input logic svc);
    tbl.push_back('{rst, i, n, we, min, en, ack, done, hw, mi, vec, pend, svc});
  endfunction
  function automatic void model_step();
    int win = -2;
    if (reset) begin
      mode = 0; m_pend = 0; m_nmi = 0; m_mask = 4'hF; m_prev = irq; m_nprev = nmi;
      return;
    end
    if (mode == 0) begin
      if (m_nmi) win = -1;
      else if (intEnable) for (int i = 3; i >= 0; i--) if (m_pend[i] && !m_mask[i]) win = i;
    end
    if (mode == 1 && intAck) begin
      if (sel < 0) m_nmi = 0;
      else m_pend[sel] = 0;
    end
    for (int i = 0; i < 4; i++) if (irq[i] && !m_prev[i]) m_pend[i] = 1;
    if (nmi && !m_nprev) m_nmi = 1;
    if (win != -2) begin mode = 1; sel = win; end
    else if (mode == 1 && intAck) mode = 2;
    else if (mode == 2 && intDone) mode = 0;
    if (maskWe) m_mask = maskIn;
    m_prev = irq;
    m_nprev = nmi;
  endfunction
  task automatic step(input logic rst, input logic [3:0] i, input logic n, input logic we,
                      input logic [3:0] min, input logic en, input logic ack, input logic done);
    reset = rst; irq = i; nmi = n; maskWe = we; maskIn = min; intEnable = en; intAck = ack; intDone = done;
    @(posedge Clk);
    model_step();
    #1;
  endtask
  task automatic check(input string name, input int idx, input logic hw, input logic mi,
                       input logic [8:0] vec, input logic [3:0] pend, input logic svc);
    logic [8:0] av = svc ? 9'd0 : intVector;
    logic [8:0] ev = svc ? 9'd0 : vec;
    vectors++;
    if ({hardwareInterrupt, maskableInterrupt, av, pending, inService} !== {hw, mi, ev, pend, svc}) begin
      miscompares++;
      $display("FAIL %s #%0d: got hw=%b mi=%b vec=%0d pend=%b svc=%b, expected hw=%b mi=%b vec=%0d pend=%b svc=%b",
               name, idx, hardwareInterrupt, maskableInterrupt, intVector, pending, inService,
               hw, mi, vec, pend, svc);
    end
  endtask
  initial begin
    //   rst irq     nmi we min   en ack done  hw mi vec  pend    svc
    add(1, 4'b0000, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0000, 0, 1, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0100, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0100, 0);
    add(0, 4'b0100, 0, 0, 4'h0, 1, 0, 0,  0, 1, 464, 4'b0100, 0);
    add(0, 4'b0100, 0, 0, 4'h0, 1, 1, 0,  0, 0, 0,   4'b0000, 1);
    add(0, 4'b0100, 0, 0, 4'h0, 1, 0, 1,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b1010, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b1010, 0);
    add(0, 4'b1010, 0, 0, 4'h0, 1, 0, 0,  0, 1, 456, 4'b1010, 0);
    add(0, 4'b1010, 0, 0, 4'h0, 1, 1, 0,  0, 0, 0,   4'b1000, 1);
    add(0, 4'b1010, 0, 0, 4'h0, 1, 0, 1,  0, 0, 0,   4'b1000, 0);
    add(0, 4'b1010, 0, 0, 4'h0, 1, 0, 0,  0, 1, 472, 4'b1000, 0);
    add(0, 4'b1010, 0, 0, 4'h0, 1, 1, 0,  0, 0, 0,   4'b0000, 1);
    add(0, 4'b1010, 0, 0, 4'h0, 1, 0, 1,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0010, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0010, 0);
    add(0, 4'b0010, 0, 0, 4'h0, 1, 0, 0,  0, 1, 456, 4'b0010, 0);
    add(0, 4'b0010, 1, 0, 4'h0, 1, 0, 0,  0, 1, 456, 4'b0010, 0);
    add(0, 4'b0010, 1, 0, 4'h0, 0, 0, 0,  0, 1, 456, 4'b0010, 0);
    add(0, 4'b0010, 1, 0, 4'h0, 1, 1, 0,  0, 0, 0,   4'b0000, 1);
    add(0, 4'b0010, 1, 0, 4'h0, 1, 0, 1,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0010, 1, 0, 4'h0, 1, 0, 0,  1, 0, 480, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'h0, 1, 1, 0,  0, 0, 0,   4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'h0, 1, 0, 1,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0000, 0, 1, 4'hF, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0001, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0001, 0);
    add(0, 4'b0001, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0001, 0);
    add(0, 4'b0001, 0, 1, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0001, 0);
    add(0, 4'b0001, 0, 0, 4'h0, 1, 0, 0,  0, 1, 448, 4'b0001, 0);
    add(0, 4'b0001, 0, 0, 4'h0, 1, 1, 0,  0, 0, 0,   4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'h0, 1, 0, 1,  0, 0, 0,   4'b0000, 0);
    add(1, 4'b0100, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0100, 0, 1, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0100, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0100, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0100, 0);
    add(0, 4'b0100, 0, 0, 4'h0, 1, 0, 0,  0, 1, 464, 4'b0100, 0);
    add(0, 4'b0100, 0, 0, 4'h0, 1, 1, 0,  0, 0, 0,   4'b0000, 1);
    add(1, 4'b0010, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0010, 0, 0, 4'h0, 1, 0, 1,  0, 0, 0,   4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'h0, 1, 0, 0,  0, 0, 0,   4'b0000, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].irq, tbl[i].nmi, tbl[i].we, tbl[i].min, tbl[i].en, tbl[i].ack, tbl[i].done);
      check("directed", i, tbl[i].hw, tbl[i].mi, tbl[i].vec, tbl[i].pend, tbl[i].svc);
    end
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 59) == 0,
           irq ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
           $urandom_range(0, 19) == 0 ? ~nmi : nmi,
           $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 5) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      check("random", i, mode == 1 && sel == -1, mode == 1 && sel >= 0,
            mode == 0 ? 9'd0 : sel == -1 ? 9'd480 : 9'(448 + 8 * sel), m_pend, mode == 2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 Clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 irq  input  4  maskable device request lines, level; a 0->1 transition is an event.
REQ-005 nmi  input  1  non-maskable request line, level; a 0->1 transition is an event.
REQ-006 maskWe  input  1  writes maskIn into the mask register at the clock edge.
REQ-007 maskIn  input  4  new mask value; 1 = source blocked.
REQ-008 intEnable  input  1  CU global enable for maskable sources.
REQ-009 intAck  input  1  CU one-cycle pulse accepting the current request.
REQ-010 intDone  input  1  CU one-cycle pulse marking end of service.
REQ-011 hardwareInterrupt  output  1  NMI request to CU.
REQ-012 maskableInterrupt  output  1  maskable request to CU.
REQ-013 intVector  output  9  trap address for the CU ramAddress/trap-mux path.
REQ-014 pending  output  4  maskable pending latches, unmasked view.
REQ-015 inService  output  1  high while in SERVICE.

Function
REQ-016 Edge detect: irqPrev/nmiPrev registers; event = line & ~prev, sampled each edge.
REQ-017 An event SHALL set its pending bit (or nmiPend) at the same edge; the bit holds until acknowledged or reset.
REQ-018 If an event and a clear hit the same bit on the same edge, set SHALL win.
REQ-019 States: IDLE, REQ, SERVICE; encoding goes in the shared package.
REQ-020 IDLE->REQ when nmiPend=1, or intEnable=1 and |(pending & ~mask)=1; the winning source is latched in selSrc at the transition.
REQ-021 Priority: NMI > irq[0] > irq[1] > irq[2] > irq[3].
REQ-022 In REQ, hardwareInterrupt=1 if selSrc=NMI, otherwise maskableInterrupt=1; the request holds until intAck.
REQ-023 In REQ, selSrc and intVector SHALL stay stable; later events, mask writes or intEnable=0 SHALL NOT withdraw or change the request.
REQ-024 REQ->SERVICE on intAck; at that edge the selected pending bit (or nmiPend) is cleared.
REQ-025 SERVICE->IDLE on intDone; requests and intAck in SERVICE are ignored, so there is no nesting; events still latch.
REQ-026 intAck outside REQ and intDone outside SERVICE SHALL be ignored.
REQ-027 intVector: NMI=9'd480, irq[n]=9'd448+8*n (448, 456, 464, 472); 9'd0 in IDLE.
REQ-028 A mask write takes effect for arbitration from the next edge.
REQ-029 Latency: an irq edge sampled at clock k asserts the request output after edge k+1, given IDLE, unmasked and enabled.
REQ-030 Masked pending bits SHALL remain set and SHALL be arbitrated once unmasked.

Reset
REQ-031 When reset=1 at an edge, the module SHALL set:
- state=IDLE
- pending=0, nmiPend=0
- mask=4'hF (all blocked)
- irqPrev=irq, nmiPrev=nmi, so a level already high is not an event
- all outputs 0
REQ-032 Reset SHALL override every other input in any state, including mid-REQ or mid-SERVICE.

Structure
REQ-033 A shared package SHALL hold:
- the state encoding
- source IDs (SRC_NMI, SRC_IRQ0..3)
- vector constants VEC_NMI=480, VEC_BASE=448, VEC_STRIDE=8
REQ-034 Use one sub-module, int_priority_encoder: combinational, inputs nmiPend and pending&~mask gated by intEnable; outputs a valid flag and the source ID.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset, mask=0, intEnable=1; irq=4'b0100 rising -> maskableInterrupt=1 two edges later, intVector=464; intAck -> pending[2]=0, inService=1; intDone -> IDLE.
- irq[3] and irq[1] rise on the same cycle -> intVector=456 first; after intDone, intVector=472 next.
- Maskable request held in REQ, then nmi rises -> the request stays with intVector=456; after ack and done, hardwareInterrupt=1 with intVector=480.
- mask=4'hF, irq[0] rises -> no request, pending=4'b0001; write mask=0 -> request with intVector=448 after the following edge.
- irq[2] held high through reset -> no event after reset; low then high -> event latched.
- reset asserted during SERVICE -> next cycle all outputs 0, pending=0; a later intDone has no effect.
